// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the transmit and receive controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    function automatic int frame_cycles(
        input int clks,
        input int dbits,
        input int par
    );
        return (2 + dbits + par) * clks;
    endfunction

    localparam int FRAME_CYCLES_DEFAULT = frame_cycles(16, 8, 0);

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled.
// Ticks on the last count and wraps; synchronous clear wins.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start, LSB-first data, optional
// even parity, stop. All line and handshake outputs registered.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_abort,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;

    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic                 parity_q;
    logic                 parity_d;
    logic                 tx_q;
    logic                 tx_d;
    logic                 ready_q;
    logic                 ready_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;

    logic tick;
    logic timer_en;
    logic timer_clr;
    logic accept;
    logic in_frame;

    assign in_frame  = (state_q != IDLE);
    assign timer_en  = in_frame;
    assign timer_clr = in_frame && tx_abort;
    assign accept    = (state_q == IDLE) && tx_start
                       && ready_q && !tx_abort;

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (timer_en),
        .clr   (timer_clr),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (in_frame && tx_abort) begin
            state_d   = IDLE;
            shreg_d   = '0;
            bit_idx_d = '0;
            tx_d      = LINE_IDLE;
            ready_d   = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d   = START;
                        shreg_d   = tx_data;
                        parity_d  = ^tx_data;
                        bit_idx_d = '0;
                        tx_d      = START_BIT;
                        ready_d   = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
                START: begin
                    // First data bit goes out as the start bit ends.
                    if (tick) begin
                        state_d   = DATA;
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == LAST_IDX) begin
                            if (PARITY_EN != 0) begin
                                state_d = PARITY;
                                tx_d    = parity_q;
                            end else begin
                                state_d = STOP;
                                tx_d    = LINE_IDLE;
                            end
                        end else begin
                            tx_d      = shreg_q[0];
                            shreg_d   = shreg_q >> 1;
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_d = STOP;
                        tx_d    = LINE_IDLE;
                    end
                end
                STOP: begin
                    if (tick) begin
                        state_d   = IDLE;
                        tx_d      = LINE_IDLE;
                        bit_idx_d = '0;
                        ready_d   = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = LINE_IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= LINE_IDLE;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: default and parity-enabled instances
// checked cycle by cycle against a bit-position line model.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_abort = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    logic       p_start = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       p_abort = 1'b0;
    logic       p_ready;
    logic       p_busy;
    logic       p_done;
    logic       p_tx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_abort (tx_abort),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx       (tx)
    );

    uart_tx_ctrl #(.PARITY_EN(1)) dut_p (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (p_start),
        .tx_data  (p_data),
        .tx_abort (p_abort),
        .tx_ready (p_ready),
        .tx_busy  (p_busy),
        .tx_done  (p_done),
        .tx       (p_tx)
    );

    // Line level k cycles after acceptance, from frame position.
    function automatic logic exp_tx(
        input logic [7:0] d,
        input bit         par,
        input int         k
    );
        int pos;
        pos = k / 16;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return d[pos-1];
        if (par && pos == 9) return ^d;
        return 1'b1;
    endfunction

    // {tx, busy, ready, done}
    function automatic logic [3:0] obs(input bit p);
        return p ? {p_tx, p_busy, p_ready, p_done}
                 : {tx, tx_busy, tx_ready, tx_done};
    endfunction

    task automatic start_byte(
        input  bit         p,
        input  logic [7:0] d,
        input  bit         hold,
        output bit         ok
    );
        int n;
        n = 0;
        ok = 1'b1;
        while (!(p ? p_ready : tx_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 400) begin
            miscompares++;
            $display("FAIL start_wait: tx_ready=0 after %0d cycles, need 1", n);
            ok = 1'b0;
            return;
        end
        if (p) begin
            p_data = d;
            p_start = 1'b1;
        end else begin
            tx_data = d;
            tx_start = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            if (p) p_start = 1'b0;
            else tx_start = 1'b0;
        end
    endtask

    // Starts at the negedge after acceptance, ends at completion negedge.
    task automatic check_frame(
        input bit         p,
        input logic [7:0] d,
        input string      tag,
        input bit         stir
    );
        int fl;
        logic [3:0] e;
        logic [3:0] o;
        fl = p ? 176 : 160;
        for (int k = 0; k < fl; k++) begin
            e = {exp_tx(d, p, k), 1'b1, 1'b0, 1'b0};
            o = obs(p);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s k=%0d {tx,busy,ready,done} got %b need %b",
                         tag, k, o, e);
            end
            if (stir && k == 20) begin
                tx_start = 1'b1;
                tx_data = ~d;
            end
            if (stir && k == 30) tx_start = 1'b0;
            @(negedge clk);
        end
        o = obs(p);
        vectors++;
        if (o !== 4'b1011) begin
            miscompares++;
            $display("FAIL %s_done k=%0d got %b need 1011", tag, fl, o);
        end
    endtask

    task automatic idle_cycles(input bit p, input int n, input string tag);
        logic [3:0] o;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            o = obs(p);
            vectors++;
            if (o !== 4'b1010) begin
                miscompares++;
                $display("FAIL %s i=%0d got %b need 1010", tag, i, o);
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] o;
        #1 rst_n = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            o = obs(p[0]);
            vectors++;
            if (o !== 4'b1010) begin
                miscompares++;
                $display("FAIL reset dut%0d got %b need 1010", p, o);
            end
        end
        rst_n = 1'b1;
        idle_cycles(0, 2, "post_reset");
        idle_cycles(1, 1, "post_reset_p");
    endtask

    task automatic test_basic();
        bit ok;
        start_byte(0, 8'hA5, 0, ok);
        if (ok) check_frame(0, 8'hA5, "a5", 0);
        idle_cycles(0, 3, "a5_idle");
    endtask

    task automatic test_back_to_back();
        bit ok;
        start_byte(0, 8'h00, 1, ok);
        tx_data = 8'hFF;
        if (ok) begin
            check_frame(0, 8'h00, "b2b0", 0);
            @(negedge clk);
            tx_start = 1'b0;
            check_frame(0, 8'hFF, "b2b1", 0);
        end
        tx_start = 1'b0;
        idle_cycles(0, 2, "b2b_idle");
    endtask

    task automatic test_parity();
        bit ok;
        start_byte(1, 8'h07, 0, ok);
        if (ok) check_frame(1, 8'h07, "par07", 0);
        idle_cycles(1, 2, "par_idle");
    endtask

    task automatic test_abort();
        bit ok;
        logic [3:0] o;
        logic [3:0] e;
        start_byte(0, 8'h5A, 0, ok);
        for (int k = 0; k < 50; k++) begin
            e = {exp_tx(8'h5A, 0, k), 3'b100};
            o = obs(0);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL abort_pre k=%0d got %b need %b", k, o, e);
            end
            if (k == 49) tx_abort = 1'b1;
            @(negedge clk);
        end
        o = obs(0);
        vectors++;
        if (o !== 4'b1010) begin
            miscompares++;
            $display("FAIL abort_edge got %b need 1010", o);
        end
        tx_abort = 1'b0;
        idle_cycles(0, 200, "abort_nodone");
        start_byte(0, 8'h3C, 0, ok);
        if (ok) check_frame(0, 8'h3C, "post_abort3c", 0);
        idle_cycles(0, 1, "3c_idle");
    endtask

    task automatic test_abort_idle();
        tx_abort = 1'b1;
        tx_start = 1'b1;
        tx_data = 8'h81;
        idle_cycles(0, 3, "abort_beats_start");
        tx_abort = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        check_frame(0, 8'h81, "after_idle_abort", 0);
        idle_cycles(0, 1, "81_idle");
    endtask

    task automatic test_busy_start();
        bit ok;
        start_byte(0, 8'h96, 0, ok);
        if (ok) check_frame(0, 8'h96, "busy_start", 1);
        tx_start = 1'b0;
        idle_cycles(0, 2, "busy_start_idle");
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] o;
        logic [3:0] e;
        start_byte(0, 8'hC3, 0, ok);
        for (int k = 0; k < 40; k++) begin
            e = {exp_tx(8'hC3, 0, k), 3'b100};
            o = obs(0);
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL rstmid_pre k=%0d got %b need %b", k, o, e);
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        o = obs(0);
        vectors++;
        if (o !== 4'b1010) begin
            miscompares++;
            $display("FAIL rst_async got %b need 1010", o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(0, 2, "rstmid_idle");
        start_byte(0, 8'h4E, 0, ok);
        if (ok) check_frame(0, 8'h4E, "post_rst4e", 0);
    endtask

    task automatic test_random();
        bit ok;
        bit p;
        logic [7:0] d;
        int gap;
        for (int i = 0; i < 8; i++) begin
            p = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            gap = $urandom_range(0, 5);
            if (gap > 0) idle_cycles(p, gap, "rnd_gap");
            start_byte(p, d, 0, ok);
            if (ok) check_frame(p, d, "rnd", 0);
        end
        idle_cycles(0, 1, "rnd_end");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_abort();
        test_abort_idle();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
